// File: rtl/jtcps_layer_pkg.sv
// Shared types, defaults and layer-walk helper for the tilemap layer sequencer.
// Latency: n/a (declarations only); backpressure: n/a.
package jtcps_layer_pkg;

    localparam int MAX_LAYERS = 8;
    localparam int IW         = 3;

    localparam int          DEF_HSTART = 64;
    localparam int          DEF_HEND   = 448;
    localparam logic [10:0] DEF_BLANK  = 11'h1ff;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT
    } state_t;

    // Lowest enabled layer strictly above k, or -1 when none is left.
    function automatic int next_layer(input logic [MAX_LAYERS-1:0] en, input int k);
        int r;
        r = -1;
        for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
            if (i > k && en[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtcps_layer_seq_if.sv
// Bundle between timing generator / tilemap engine (master) and the layer sequencer (slave).
// Latency: n/a (wires only); backpressure: none, engine paces jobs via tm_done.
interface jtcps_layer_seq_if #(
    parameter int LAYERS = 3,
    parameter int DW     = 11,
    parameter int AW     = 9,
    parameter int PW     = 16
);
    logic                   pxl_cen;
    logic                   flip;
    logic [AW-1:0]          hdump;
    logic                   preVB;
    logic                   VB;
    logic                   HB;
    logic                   line_start;
    logic [LAYERS-1:0]      layer_en;
    logic [LAYERS*PW-1:0]   hpos_all;
    logic [LAYERS*PW-1:0]   vpos_all;
    logic [PW-1:0]          tm_hpos;
    logic [PW-1:0]          tm_vpos;
    logic [LAYERS-1:0]      tm_layer;
    logic                   tm_start;
    logic                   tm_stop;
    logic                   tm_done;
    logic                   buf_wr;
    logic [AW-1:0]          buf_addr;
    logic [DW-1:0]          buf_data;
    logic [LAYERS*DW-1:0]   pxl_all;
    logic                   busy;
    logic                   line_done;
    logic [7:0]             overrun_cnt;

    modport master (
        output pxl_cen, flip, hdump, preVB, VB, HB, line_start, layer_en,
               hpos_all, vpos_all, tm_done, buf_wr, buf_addr, buf_data,
        input  tm_hpos, tm_vpos, tm_layer, tm_start, tm_stop, pxl_all,
               busy, line_done, overrun_cnt
    );

    modport slave (
        input  pxl_cen, flip, hdump, preVB, VB, HB, line_start, layer_en,
               hpos_all, vpos_all, tm_done, buf_wr, buf_addr, buf_data,
        output tm_hpos, tm_vpos, tm_layer, tm_start, tm_stop, pxl_all,
               busy, line_done, overrun_cnt
    );

endinterface

// File: rtl/jtcps_layer_linebuf.sv
// Double-banked line buffer for one layer; the bank is the address MSB.
// Latency: 1 cycle read; backpressure: none.
module jtcps_layer_linebuf #(
    parameter int DW = 11,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW:0]   wr_addr_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic [AW:0]   rd_addr_i,
    output logic [DW-1:0] rd_dat_o
);

    jtframe_dual_ram #(.dw(DW), .aw(AW+1)) u_ram (
        .clk0  (clk),
        .data0 (wr_dat_i),
        .addr0 (wr_addr_i),
        .we0   (we_i),
        .clk1  (clk),
        .addr1 (rd_addr_i),
        .q1    (rd_dat_o)
    );

endmodule

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with a registered output.
// Latency: 1 cycle read; backpressure: none.
module jtframe_dual_ram #(
    parameter int dw = 8,
    parameter int aw = 10
) (
    input  logic          clk0,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    input  logic          clk1,
    input  logic [aw-1:0] addr1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem [0:(1<<aw)-1];

    always_ff @(posedge clk0) begin
        if (we0) mem[addr0] <= data0;
    end

    always_ff @(posedge clk1) begin
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtcps_layer_seq.sv
// Per-line tilemap layer sequencer with line-buffered replay; JTCPS_OVERRUN_EN adds the overrun counter.
// Latency: req_edge->tm_start 3 cycles, pixels 2 cycles; backpressure: none, a late line is aborted.
module jtcps_layer_seq
    import jtcps_layer_pkg::*;
#(
    parameter int             LAYERS = 3,
    parameter int             DW     = 11,
    parameter int             AW     = 9,
    parameter int             PW     = 16,
    parameter int             HSTART = DEF_HSTART,
    parameter int             HEND   = DEF_HEND,
    parameter logic [DW-1:0]  BLANK  = DW'(DEF_BLANK)
) (
    input  logic clk,
    input  logic rst_n,
    jtcps_layer_seq_if.slave bus
);

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   pending_q, pending_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q;
    logic                   hb_q, ls_q;
    logic [PW-1:0]          hpos_q, vpos_q, hsel, vsel;
    logic [MAX_LAYERS-1:0]  en8;
    logic [LAYERS-1:0]      lay_oh;
    logic                   req_edge, busy, overrun, line_done, tm_stop;
    int                     first_l, next_l;

    assign req_edge = hb_q & ~bus.HB & (~bus.preVB | ~bus.VB);
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = req_edge & busy;

    always_comb begin
        en8 = '0;
        en8[LAYERS-1:0] = bus.layer_en;
        first_l = next_layer(en8, -1);
        next_l  = next_layer(en8, int'(idx_q));
    end

    always_comb begin
        lay_oh = '0;
        hsel   = '0;
        vsel   = '0;
        for (int k = 0; k < LAYERS; k++) begin
            if (int'(idx_q) == k) begin
                lay_oh[k] = 1'b1;
                hsel      = bus.hpos_all[k*PW +: PW];
                vsel      = bus.vpos_all[k*PW +: PW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        wr_bank_d = wr_bank_q;
        line_done = 1'b0;
        tm_stop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    if (first_l >= 0) begin
                        idx_d   = first_l[IW-1:0];
                        state_d = ST_LOAD;
                    end else begin
                        wr_bank_d = ~wr_bank_q;
                        line_done = 1'b1;
                    end
                end
            end
            ST_LOAD:  state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.tm_done) begin
                    if (next_l >= 0) begin
                        idx_d   = next_l[IW-1:0];
                        state_d = ST_LOAD;
                    end else begin
                        wr_bank_d = ~wr_bank_q;
                        line_done = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (req_edge) pending_d = 1'b1;
        // A new line arriving mid-walk wins: drop the current job, close the line once.
        if (overrun) begin
            tm_stop   = 1'b1;
            line_done = 1'b1;
            wr_bank_d = ~wr_bank_q;
            idx_d     = idx_q;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            wr_bank_q <= 1'b1;
            rd_bank_q <= 1'b0;
            hb_q      <= 1'b0;
            ls_q      <= 1'b0;
            hpos_q    <= '0;
            vpos_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            wr_bank_q <= wr_bank_d;
            hb_q      <= bus.HB;
            ls_q      <= bus.line_start;
            if (bus.line_start && !ls_q) rd_bank_q <= ~wr_bank_q;
            if (state_q == ST_LOAD) begin
                hpos_q <= hsel;
                vpos_q <= vsel;
            end
        end
    end

    assign bus.tm_hpos   = hpos_q;
    assign bus.tm_vpos   = vpos_q;
    assign bus.tm_layer  = lay_oh;
    assign bus.tm_start  = (state_q == ST_START);
    assign bus.tm_stop   = tm_stop;
    assign bus.busy      = busy;
    assign bus.line_done = line_done;

`ifdef JTCPS_OVERRUN_EN
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (overrun && ovr_q != 8'hff) ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= '0;
        else        ovr_q <= ovr_d;
    end

    assign bus.overrun_cnt = ovr_q;
`else
    assign bus.overrun_cnt = 8'd0;
`endif

    logic [DW-1:0]        rd_dat [LAYERS];
    logic [AW-1:0]        wr_addr;
    logic [LAYERS*DW-1:0] pxl_q, pxl_d;
    logic                 active;

    assign wr_addr = bus.buf_addr ^ {AW{bus.flip}};

    for (genvar k = 0; k < LAYERS; k++) begin : g_buf
        jtcps_layer_linebuf #(.DW(DW), .AW(AW)) u_buf (
            .clk       (clk),
            .we_i      (bus.buf_wr & lay_oh[k]),
            .wr_addr_i ({wr_bank_q, wr_addr}),
            .wr_dat_i  (bus.buf_data),
            .rd_addr_i ({rd_bank_q, bus.hdump}),
            .rd_dat_o  (rd_dat[k])
        );
    end

    assign active = (32'(bus.hdump) >= 32'(HSTART)) && (32'(bus.hdump) < 32'(HEND));

    always_comb begin
        pxl_d = '0;
        for (int k = 0; k < LAYERS; k++) begin
            pxl_d[k*DW +: DW] = (active && bus.layer_en[k]) ? rd_dat[k] : BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pxl_q <= {LAYERS{BLANK}};
        else if (bus.pxl_cen) pxl_q <= pxl_d;
    end

    assign bus.pxl_all = pxl_q;

endmodule
